sched_region_ctrl: RTL and testbench

- Hardware model of the simulator's per-time-step event scheduler: orders signal update events between an Active region and a Non-Blocking-Assignment (NBA) region.
- NREQ requesters post update events (signal id, 4-state value, region). The block arbitrates them round-robin into two per-region queues.
- On each step_start it drains the queues in IEEE order (Active first, then NBA, re-entering Active whenever new Active events appear) toward a single update consumer, and pulses step_done when both queues are empty.
- Sits between the process/gate evaluators (requesters) and the net-value store (consumer).

---
 rtl/sched_pkg.sv | 33 +++
 rtl/sched_fifo.sv | 56 +++++
 rtl/sched_region_ctrl.sv | 163 ++++++++++++++++
 tb/tb_sched_region_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sched_pkg.sv
// Shared types for the per-time-step event scheduler: 4-state values,
// scheduling regions, controller states and the queued event record.
package sched_pkg;

  typedef enum logic [1:0] {
    L0 = 2'b00,
    L1 = 2'b01,
    LX = 2'b10,
    LZ = 2'b11
  } logic4_t;

  typedef enum logic {
    REG_ACT = 1'b0,
    REG_NBA = 1'b1
  } region_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACT  = 2'd1,
    NBA  = 2'd2,
    DONE = 2'd3
  } sched_state_t;

  // Default-width event record; modules with a different IDW declare the
  // same layout locally.
  localparam int SCHED_IDW = 8;

  typedef struct packed {
    logic [SCHED_IDW-1:0] id;
    logic4_t              val;
  } sched_evt_t;

endpackage

// File: rtl/sched_fifo.sv
// Synchronous FIFO with first-word-fall-through head; one instance per
// scheduling region. Full/empty derive only from registered state.
module sched_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // NOTE: storage is deliberately left unreset; the pointers and count are
  // what define validity, and the top gates payload outputs with upd_valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sched_region_ctrl.sv
// Time-step event scheduler: round-robin intake into Active/NBA queues and
// an IEEE-ordered drain (Active first, re-entering Active as events appear).
module sched_region_ctrl
  import sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DEPTH = 8,
  parameter int IDW   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*IDW-1:0] req_id,
  input  logic [NREQ*2-1:0] req_val,
  input  logic [NREQ-1:0]   req_nba,
  output logic [NREQ-1:0]   req_ready,
  input  logic              step_start,
  output logic              upd_valid,
  input  logic              upd_ready,
  output logic [IDW-1:0]    upd_id,
  output logic [1:0]        upd_val,
  output logic              upd_nba,
  output logic              busy,
  output logic              step_done
);

  localparam int PW = $clog2(NREQ);

  typedef struct packed {
    logic [IDW-1:0] id;
    logic4_t        val;
  } evt_t;

  function automatic logic [PW-1:0] wrap_idx(input int base, input int off);
    return PW'((base + off) % NREQ);
  endfunction

  sched_state_t  state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [NREQ-1:0] elig;
  logic          gnt_found;
  logic [PW-1:0] gnt_idx;
  region_t       push_region;
  evt_t          push_evt;
  logic          act_push, nba_push, act_pop, nba_pop;
  logic          act_full, nba_full, act_empty, nba_empty;
  evt_t          act_head, nba_head;

  // A requester is eligible only if the queue it targets has room.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = req_valid[i] & ~(req_nba[i] ? nba_full : act_full);
    end
  end

  // NOTE: combinational blocks use blocking assignments with every output
  // defaulted first, so the search below reads its own earlier result and no
  // latch can form.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_found && elig[wrap_idx(int'(ptr_q), k)]) begin
        gnt_found = 1'b1;
        gnt_idx   = wrap_idx(int'(ptr_q), k);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (gnt_found && rst_n) req_ready[gnt_idx] = 1'b1;
  end

  assign ptr_d        = wrap_idx(int'(gnt_idx), 1);
  assign push_region  = region_t'(req_nba[gnt_idx]);
  assign push_evt.id  = req_id[gnt_idx*IDW +: IDW];
  assign push_evt.val = logic4_t'(req_val[gnt_idx*2 +: 2]);
  assign act_push     = gnt_found && (push_region == REG_ACT);
  assign nba_push     = gnt_found && (push_region == REG_NBA);

  sched_fifo #(.DEPTH(DEPTH), .W(IDW+2)) u_act_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (act_push),
    .pop_i   (act_pop),
    .din_i   (push_evt),
    .full_o  (act_full),
    .empty_o (act_empty),
    .head_o  (act_head)
  );

  sched_fifo #(.DEPTH(DEPTH), .W(IDW+2)) u_nba_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (nba_push),
    .pop_i   (nba_pop),
    .din_i   (push_evt),
    .full_o  (nba_full),
    .empty_o (nba_empty),
    .head_o  (nba_head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (gnt_found) ptr_q <= ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    upd_valid = 1'b0;
    upd_id    = '0;
    upd_val   = 2'b00;
    upd_nba   = 1'b0;
    act_pop   = 1'b0;
    nba_pop   = 1'b0;
    busy      = 1'b0;
    step_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (step_start) state_d = ACT;
      end
      ACT: begin
        busy      = 1'b1;
        upd_valid = ~act_empty;
        if (upd_valid) begin
          upd_id  = act_head.id;
          upd_val = act_head.val;
        end
        act_pop = upd_valid & upd_ready;
        if (act_empty && !act_push) state_d = NBA;
      end
      NBA: begin
        busy      = 1'b1;
        upd_nba   = 1'b1;
        upd_valid = ~nba_empty;
        if (upd_valid) begin
          upd_id  = nba_head.id;
          upd_val = nba_head.val;
        end
        nba_pop = upd_valid & upd_ready;
        // An offered NBA update is never withdrawn; re-enter Active only once
        // nothing is left hanging on the consumer interface.
        if (!act_empty && !(upd_valid && !upd_ready)) begin
          state_d = ACT;
        end else if (act_empty && nba_empty && !act_push && !nba_push) begin
          state_d = DONE;
        end
      end
      DONE: begin
        step_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sched_region_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic, checked
// against a queue-based scheduler model (arbitration, FIFO order, drain).
module tb_sched_region_ctrl;
  import sched_pkg::*;

  localparam int NREQ  = 4;
  localparam int DEPTH = 8;
  localparam int IDW   = 8;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ*IDW-1:0] req_id = '0;
  logic [NREQ*2-1:0]   req_val = '0;
  logic [NREQ-1:0]     req_nba = '0;
  logic [NREQ-1:0]     req_ready;
  logic                step_start = 1'b0;
  logic                upd_valid;
  logic                upd_ready = 1'b0;
  logic [IDW-1:0]      upd_id;
  logic [1:0]          upd_val;
  logic                upd_nba;
  logic                busy;
  logic                step_done;

  sched_region_ctrl #(.NREQ(NREQ), .DEPTH(DEPTH), .IDW(IDW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_id     (req_id),
    .req_val    (req_val),
    .req_nba    (req_nba),
    .req_ready  (req_ready),
    .step_start (step_start),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .upd_id     (upd_id),
    .upd_val    (upd_val),
    .upd_nba    (upd_nba),
    .busy       (busy),
    .step_done  (step_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IDW-1:0] id;
    logic [1:0]     val;
    logic           nba;
  } upd_t;

  upd_t m_act[$];
  upd_t m_nba[$];
  upd_t log_q[$];
  int   m_ptr;
  int   n_checks = 0;
  int   n_pass   = 0;

  logic            s_busy, s_done, s_updv, s_nba;
  logic [NREQ-1:0] s_ready;
  logic [IDW-1:0]  s_id;
  logic            prev_stall = 1'b0;
  logic [IDW-1:0]  prev_id;
  logic [1:0]      prev_val;
  logic            prev_nba;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_clear();
    m_act.delete();
    m_nba.delete();
    m_ptr      = 0;
    prev_stall = 1'b0;
  endtask

  // One clock of reference behaviour, evaluated on the falling edge.
  task automatic model_step();
    logic [NREQ-1:0] exp_gnt;
    int   gidx;
    int   qsize;
    upd_t e, h;
    s_busy = busy; s_done = step_done; s_updv = upd_valid;
    s_ready = req_ready; s_id = upd_id; s_nba = upd_nba;

    exp_gnt = '0;
    gidx    = -1;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      bit full;
      idx  = (m_ptr + k) % NREQ;
      full = req_nba[idx] ? (m_nba.size() == DEPTH) : (m_act.size() == DEPTH);
      if (gidx < 0 && req_valid[idx] && !full) begin
        gidx         = idx;
        exp_gnt[idx] = 1'b1;
      end
    end
    check("req_ready", 32'(req_ready), 32'(exp_gnt));

    if (prev_stall) begin
      check("stall_valid", 32'(upd_valid), 32'd1);
      check("stall_payload", 32'({upd_id, upd_val, upd_nba}),
            32'({prev_id, prev_val, prev_nba}));
    end
    if (upd_valid) check("valid_implies_busy", 32'(busy), 32'd1);

    if (upd_valid && upd_ready) begin
      e = '{upd_id, upd_val, upd_nba};
      log_q.push_back(e);
      qsize = upd_nba ? m_nba.size() : m_act.size();
      check("upd_has_source", 32'(qsize != 0), 32'd1);
      if (qsize != 0) begin
        if (upd_nba) h = m_nba.pop_front();
        else         h = m_act.pop_front();
        check("upd_id", 32'(upd_id), 32'(h.id));
        check("upd_val", 32'(upd_val), 32'(h.val));
      end
    end

    if (step_done) begin
      check("done_act_empty", 32'(m_act.size()), 32'd0);
      check("done_nba_empty", 32'(m_nba.size()), 32'd0);
    end

    if (gidx >= 0) begin
      e = '{req_id[gidx*IDW +: IDW], req_val[gidx*2 +: 2], req_nba[gidx]};
      if (e.nba) m_nba.push_back(e);
      else       m_act.push_back(e);
      m_ptr = (gidx + 1) % NREQ;
    end

    prev_stall = upd_valid && !upd_ready;
    prev_id    = upd_id;
    prev_val   = upd_val;
    prev_nba   = upd_nba;
  endtask

  task automatic cycle();
    @(negedge clk);
    if (rst_n) model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [IDW-1:0] id,
                         input logic [1:0] val, input logic nba);
    req_valid[i]           = v;
    req_id[i*IDW +: IDW]   = id;
    req_val[i*2 +: 2]      = val;
    req_nba[i]             = nba;
  endtask

  task automatic post_one(input int i, input logic [IDW-1:0] id,
                          input logic [1:0] val, input logic nba);
    set_req(i, 1'b1, id, val, nba);
    cycle();
    req_valid[i] = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || step_done) && n < 300) begin
      cycle();
      n++;
    end
    if (busy || step_done) check("idle_timeout", 32'(busy | step_done), 32'd0);
  endtask

  task automatic pulse_start();
    wait_idle();
    step_start = 1'b1;
    cycle();
    step_start = 1'b0;
  endtask

  task automatic run_step(input string tag);
    int n = 0;
    bit seen = 1'b0;
    pulse_start();
    while (!seen && n < 300) begin
      cycle();
      seen = s_done;
      n++;
    end
    check({tag, "_done"}, 32'(seen), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt, done_at, n, p;
    bit updv_seen, injected, seen, ok;

    // Reset values, with requests pending to show req_ready stays low.
    req_valid = '1;
    #12;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_outputs", 32'({upd_valid, upd_id, upd_val, upd_nba, busy, step_done}), 32'd0);
    req_valid = '0;
    do_reset();

    // Empty step: ACT, NBA, DONE.
    pulse_start();
    busy_cnt = 0; done_at = 0; updv_seen = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      cycle();
      if (s_busy) busy_cnt++;
      if (s_done && done_at == 0) done_at = k;
      if (s_updv) updv_seen = 1'b1;
    end
    check("t1_busy_cycles", 32'(busy_cnt), 32'd2);
    check("t1_done_latency", 32'(done_at), 32'd3);
    check("t1_no_update", 32'(updv_seen), 32'd0);

    // Active before NBA for the same signal.
    post_one(0, 8'd5, L1, 1'b0);
    post_one(1, 8'd5, L0, 1'b1);
    log_q.delete();
    upd_ready = 1'b1;
    run_step("t2");
    check("t2_count", 32'(log_q.size()), 32'd2);
    if (log_q.size() == 2) begin
      check("t2_first", 32'({log_q[0].id, log_q[0].val, log_q[0].nba}), 32'({8'd5, 2'b01, 1'b0}));
      check("t2_second", 32'({log_q[1].id, log_q[1].val, log_q[1].nba}), 32'({8'd5, 2'b00, 1'b1}));
    end

    // Round-robin rotation, full Active queue blocks only Active requesters.
    do_reset();
    upd_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 8'(8'h60 + i), L1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      cycle();
      check("t3_rr_grant", 32'(s_ready), 32'(1 << (k % 4)));
    end
    cycle();
    check("t3_full_block", 32'(s_ready), 32'd0);
    req_nba[3] = 1'b1;
    cycle();
    check("t3_nba_pass", 32'(s_ready), 32'h8);
    req_valid = '0;
    log_q.delete();
    upd_ready = 1'b1;
    run_step("t3");
    check("t3_count", 32'(log_q.size()), 32'd9);
    if (log_q.size() == 9) begin
      check("t3_head", 32'(log_q[0].id), 32'h60);
      check("t3_last_nba", 32'(log_q[8].nba), 32'd1);
    end

    // Active event arriving mid-NBA drain is serviced before remaining NBA.
    for (int k = 0; k < 5; k++) post_one(1, 8'(20 + k), 2'(k), 1'b1);
    log_q.delete();
    upd_ready = 1'b1;
    pulse_start();
    injected = 1'b0; seen = 1'b0; n = 0;
    while (!seen && n < 100) begin
      cycle();
      n++;
      if (s_done) seen = 1'b1;
      if (req_valid[2]) req_valid[2] = 1'b0;
      else if (!injected && log_q.size() > 0) begin
        set_req(2, 1'b1, 8'd9, L1, 1'b0);
        injected = 1'b1;
      end
    end
    check("t4_done", 32'(seen), 32'd1);
    check("t4_count", 32'(log_q.size()), 32'd6);
    p = -1;
    foreach (log_q[i]) if (log_q[i].id == 8'd9 && !log_q[i].nba) p = i;
    ok = (p > 0) && (p < log_q.size() - 1);
    check("t4_act_reentry", 32'(ok), 32'd1);

    // Stalled NBA offer holds steady and is not abandoned for Active work.
    post_one(1, 8'd30, LX, 1'b1);
    post_one(1, 8'd31, LZ, 1'b1);
    upd_ready = 1'b0;
    pulse_start();
    n = 0;
    while (!(upd_valid && upd_nba) && n < 20) begin
      cycle();
      n++;
    end
    check("t5_offer", 32'(upd_valid && upd_nba), 32'd1);
    set_req(0, 1'b1, 8'd40, L0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cycle();
      req_valid[0] = 1'b0;
      check("t5_hold", 32'({s_updv, s_id, s_nba, s_busy}), 32'({1'b1, 8'd30, 1'b1, 1'b1}));
    end
    log_q.delete();
    upd_ready = 1'b1;
    seen = 1'b0; n = 0;
    while (!seen && n < 50) begin
      cycle();
      n++;
      seen = s_done;
    end
    check("t5_done", 32'(seen), 32'd1);
    check("t5_count", 32'(log_q.size()), 32'd3);
    if (log_q.size() == 3) begin
      check("t5_order", 32'({log_q[0].id, log_q[1].id, log_q[2].id}), 32'({8'd30, 8'd40, 8'd31}));
    end

    // Asynchronous reset in the middle of an Active drain.
    do_reset();
    for (int k = 0; k < 3; k++) post_one(0, 8'(50 + k), L1, 1'b0);
    upd_ready = 1'b0;
    pulse_start();
    n = 0;
    while (!upd_valid && n < 10) begin
      cycle();
      n++;
    end
    check("t6_offer", 32'(upd_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_drop", 32'({upd_valid, busy, upd_id, req_ready}), 32'd0);
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    log_q.delete();
    upd_ready = 1'b1;
    run_step("t6");
    check("t6_discarded", 32'(log_q.size()), 32'd0);

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        set_req(i, 1'($urandom % 3 == 0), 8'($urandom), 2'($urandom), 1'($urandom));
      end
      upd_ready  = ($urandom % 4) != 0;
      step_start = ($urandom % 10) == 0;
      cycle();
    end
    req_valid  = '0;
    step_start = 1'b0;
    upd_ready  = 1'b1;
    run_step("rand");
    check("rand_act_drained", 32'(m_act.size()), 32'd0);
    check("rand_nba_drained", 32'(m_nba.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
